// File: rtl/uart_cmd_parser_pkg.sv
// Shared packet-framing definitions for the UART command parser.
// Covers the start-of-frame byte, the parser states, the LEN field width and the checksum step.
package uart_cmd_parser_pkg;

    localparam logic [7:0] PKT_SOF = 8'hA5;
    localparam int         LEN_W   = 5;

    typedef enum logic [2:0] {
        WAIT_SOF    = 3'd0,
        GET_CMD     = 3'd1,
        GET_LEN     = 3'd2,
        GET_PAYLOAD = 3'd3,
        GET_CHK     = 3'd4
    } pkt_state_e;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte idle counter: cleared by clr_i, counts while en_i is high.
// expire_o fires when the count reaches TIMEOUT_CLKS-1 and clr_i is low in the same cycle.
module uart_pkt_timeout #(
    parameter int TIMEOUT_CLKS = 21700
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int               CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: cleared by a byte or when idle, saturates at the expiry value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q >= LAST) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt_q >= LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the UART byte stream into SOF/CMD/LEN/payload/CHK packets and presents them on a valid/ready port.
// Bad, timed-out or overrun packets are dropped and reported as one-cycle error pulses.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int MAX_LEN      = 4,
    parameter int TIMEOUT_CLKS = 21700
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_DV,
    input  logic [7:0]           i_RX_Byte,
    output logic                 o_Cmd_Valid,
    input  logic                 i_Cmd_Ready,
    output logic [7:0]           o_Cmd,
    output logic [LEN_W-1:0]     o_Len,
    output logic [MAX_LEN*8-1:0] o_Payload,
    output logic                 o_Err_Chk,
    output logic                 o_Err_Len,
    output logic                 o_Err_Timeout,
    output logic                 o_Err_Overrun
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    pkt_state_e           state_q, state_d;
    logic [7:0]           cmd_w_q, cmd_w_d;
    logic [LEN_W-1:0]     len_w_q, len_w_d;
    logic [7:0]           chk_q, chk_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           buf_q [MAX_LEN];
    logic [7:0]           buf_d [MAX_LEN];
    logic                 err_chk_d, err_len_d, err_tmo_d, err_ovr_d;
    logic                 commit_s, commit_ok_s, tmo_exp_s;
    logic                 valid_d;
    logic [MAX_LEN*8-1:0] payload_s;

    uart_pkt_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
        .clk_i    (i_Clk),
        .rst_ni   (i_Rst_L),
        .clr_i    (i_RX_DV),
        .en_i     (state_q != WAIT_SOF),
        .expire_o (tmo_exp_s)
    );

    // Parser next-state: advances only on byte strobes, timeout wins only when no byte arrives
    always_comb begin
        state_d   = state_q;
        cmd_w_d   = cmd_w_q;
        len_w_d   = len_w_q;
        chk_d     = chk_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        commit_s  = 1'b0;
        if (tmo_exp_s) begin
            state_d   = WAIT_SOF;
            err_tmo_d = 1'b1;
        end else if (i_RX_DV) begin
            case (state_q)
                WAIT_SOF: begin
                    if (i_RX_Byte == PKT_SOF) begin
                        state_d = GET_CMD;
                    end else begin
                        state_d = WAIT_SOF;
                    end
                end
                GET_CMD: begin
                    cmd_w_d = i_RX_Byte;
                    chk_d   = i_RX_Byte;
                    state_d = GET_LEN;
                end
                GET_LEN: begin
                    if (i_RX_Byte > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = WAIT_SOF;
                    end else begin
                        len_w_d = i_RX_Byte[LEN_W-1:0];
                        chk_d   = chk_update(chk_q, i_RX_Byte);
                        idx_d   = '0;
                        state_d = (i_RX_Byte == 8'h00) ? GET_CHK : GET_PAYLOAD;
                    end
                end
                GET_PAYLOAD: begin
                    buf_d[idx_q] = i_RX_Byte;
                    chk_d        = chk_update(chk_q, i_RX_Byte);
                    if (LEN_W'(idx_q) == len_w_q - LEN_W'(1)) begin
                        state_d = GET_CHK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                GET_CHK: begin
                    if (i_RX_Byte != chk_q) begin
                        err_chk_d = 1'b1;
                    end else begin
                        commit_s = 1'b1;
                    end
                    state_d = WAIT_SOF;
                end
                default: state_d = WAIT_SOF;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output handshake: a commit needs a free or simultaneously drained output slot
    always_comb begin
        commit_ok_s = commit_s && (!o_Cmd_Valid || i_Cmd_Ready);
        err_ovr_d   = commit_s && o_Cmd_Valid && !i_Cmd_Ready;
        if (commit_ok_s) begin
            valid_d = 1'b1;
        end else if (o_Cmd_Valid && i_Cmd_Ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = o_Cmd_Valid;
        end
        payload_s = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < int'(len_w_q)) begin
                payload_s[8*k +: 8] = buf_q[k];
            end else begin
                payload_s[8*k +: 8] = 8'h00;
            end
        end
    end

    // Parser state and working buffer
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= WAIT_SOF;
            cmd_w_q <= 8'h00;
            len_w_q <= '0;
            chk_q   <= 8'h00;
            idx_q   <= '0;
            buf_q   <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            cmd_w_q <= cmd_w_d;
            len_w_q <= len_w_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // Registered packet output and error pulses
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Cmd_Valid   <= 1'b0;
            o_Cmd         <= 8'h00;
            o_Len         <= '0;
            o_Payload     <= '0;
            o_Err_Chk     <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Err_Overrun <= 1'b0;
        end else begin
            o_Cmd_Valid   <= valid_d;
            o_Err_Chk     <= err_chk_d;
            o_Err_Len     <= err_len_d;
            o_Err_Timeout <= err_tmo_d;
            o_Err_Overrun <= err_ovr_d;
            if (commit_ok_s) begin
                o_Cmd     <= cmd_w_q;
                o_Len     <= len_w_q;
                o_Payload <= payload_s;
            end else begin
                o_Cmd     <= o_Cmd;
                o_Len     <= o_Len;
                o_Payload <= o_Payload;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a packet-level model is compared on every cycle, plus literal spot checks.
module tb_uart_cmd_parser;

    localparam int MAX_LEN = 4;
    localparam int T       = 40;
    localparam int PW      = MAX_LEN * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          ready = 1'b1;
    logic          valid, e_chk, e_len, e_tmo, e_ovr;
    logic [7:0]    cmd;
    logic [4:0]    len;
    logic [PW-1:0] pay;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0]    q[$];
    int            idle = 0;
    logic          m_valid = 1'b0, m_echk = 1'b0, m_elen = 1'b0, m_etmo = 1'b0, m_eovr = 1'b0;
    logic [7:0]    m_cmd = 8'h00;
    logic [4:0]    m_len = 5'd0;
    logic [PW-1:0] m_pay = '0;
    logic          m_acc, m_commit;
    logic [7:0]    x, n_cmd;
    logic [4:0]    n_len;
    logic [PW-1:0] n_pay;

    uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(T)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
        .o_Cmd_Valid(valid), .i_Cmd_Ready(ready), .o_Cmd(cmd), .o_Len(len), .o_Payload(pay),
        .o_Err_Chk(e_chk), .o_Err_Len(e_len), .o_Err_Timeout(e_tmo), .o_Err_Overrun(e_ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: collect bytes after SOF, judge the packet when its length is known
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete(); idle = 0;
                m_valid = 1'b0; m_cmd = 8'h00; m_len = 5'd0; m_pay = '0;
                m_echk = 1'b0; m_elen = 1'b0; m_etmo = 1'b0; m_eovr = 1'b0;
            end else begin
                m_acc = m_valid && ready;
                m_commit = 1'b0;
                m_echk = 1'b0; m_elen = 1'b0; m_etmo = 1'b0; m_eovr = 1'b0;
                if (rx_dv) begin
                    idle = 0;
                    if (q.size() == 0) begin
                        if (rx_byte == 8'hA5) q.push_back(rx_byte);
                    end else begin
                        q.push_back(rx_byte);
                        if (q.size() == 3 && int'(q[2]) > MAX_LEN) begin
                            m_elen = 1'b1;
                            q.delete();
                        end else if (q.size() >= 3 && q.size() == 4 + int'(q[2])) begin
                            x = 8'h00;
                            for (int i = 1; i < q.size() - 1; i++) x = x ^ q[i];
                            if (x != q[q.size()-1]) begin
                                m_echk = 1'b1;
                            end else begin
                                m_commit = 1'b1;
                                n_cmd = q[1];
                                n_len = q[2][4:0];
                                n_pay = '0;
                                for (int k = 0; k < int'(q[2]); k++) n_pay[8*k +: 8] = q[3+k];
                            end
                            q.delete();
                        end
                    end
                end else if (q.size() > 0) begin
                    idle++;
                    if (idle == T) begin
                        m_etmo = 1'b1;
                        q.delete();
                        idle = 0;
                    end
                end
                if (m_commit) begin
                    if (!m_valid || ready) begin
                        m_valid = 1'b1; m_cmd = n_cmd; m_len = n_len; m_pay = n_pay;
                    end else begin
                        m_eovr = 1'b1;
                    end
                end else if (m_acc) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Per-cycle compare on the falling edge
    initial begin
        @(negedge rst_n);
        forever begin
            @(negedge clk);
            check("valid", valid, m_valid);
            check("err_chk", e_chk, m_echk);
            check("err_len", e_len, m_elen);
            check("err_tmo", e_tmo, m_etmo);
            check("err_ovr", e_ovr, m_eovr);
            if (m_valid) begin
                check("cmd", cmd, m_cmd);
                check("len", len, m_len);
                check("payload", pay, m_pay);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        tick(1);
        rx_dv = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2, b3, b4, b5, input int n);
        logic [7:0] v[6];
        v = '{b0, b1, b2, b3, b4, b5};
        for (int i = 0; i < n; i++) send(v[i]);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick(2);
        check("rst_valid", valid, 1'b0);
        check("rst_cmd", cmd, 8'h00);
        check("rst_payload", pay, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // 1: good packet, valid the cycle after the CHK strobe
        send_pkt(8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 6);
        check("t1_valid", valid, 1'b1);
        check("t1_cmd", cmd, 8'h10);
        check("t1_len", len, 5'd2);
        check("t1_payload", pay, 32'h0000_2211);
        check("t1_model_pay", m_pay, 32'h0000_2211);
        tick(2);

        // 2: bad checksum, then a zero-length packet
        send_pkt(8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h00, 6);
        check("t2_err_chk", e_chk, 1'b1);
        check("t2_novalid", valid, 1'b0);
        tick(1);
        check("t2_pulse_end", e_chk, 1'b0);
        send_pkt(8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 4);
        check("t2_cmd", cmd, 8'h01);
        check("t2_len", len, 5'd0);
        tick(2);

        // 3: garbage, oversize LEN, then a good packet carrying A5 as payload
        send_pkt(8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07, 8'h05, 6);
        check("t3_err_len", e_len, 1'b1);
        send_pkt(8'hA5, 8'h02, 8'h01, 8'hA5, 8'hA6, 8'h00, 5);
        check("t3_cmd", cmd, 8'h02);
        check("t3_payload", pay, 32'h0000_00A5);
        tick(2);

        // 4: timeout mid-packet, then a byte landing exactly on the expiry cycle
        send(8'hA5); send(8'h10);
        tick(T);
        check("t4_err_tmo", e_tmo, 1'b1);
        tick(1);
        send(8'hA5); send(8'h10);
        tick(T - 1);
        send(8'h00);
        check("t4_no_tmo", e_tmo, 1'b0);
        send(8'h10);
        check("t4_valid", valid, 1'b1);
        tick(2);

        // 5: output held, second packet overruns, then drained
        ready = 1'b0;
        send_pkt(8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 6);
        send_pkt(8'hA5, 8'h20, 8'h01, 8'h44, 8'h65, 8'h00, 5);
        check("t5_err_ovr", e_ovr, 1'b1);
        check("t5_held_cmd", cmd, 8'h10);
        check("t5_held_pay", pay, 32'h0000_2211);
        ready = 1'b1;
        tick(1);
        check("t5_drained", valid, 1'b0);
        tick(1);

        // 6: accept in the commit cycle swaps data, then reset mid-payload
        ready = 1'b0;
        send_pkt(8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 6);
        send_pkt(8'hA5, 8'h20, 8'h01, 8'h44, 8'h00, 8'h00, 4);
        ready = 1'b1;
        send(8'h65);
        check("t6_valid", valid, 1'b1);
        check("t6_cmd", cmd, 8'h20);
        check("t6_payload", pay, 32'h0000_0044);
        check("t6_no_ovr", e_ovr, 1'b0);
        tick(2);
        ready = 1'b0;
        send_pkt(8'hA5, 8'h30, 8'h01, 8'h77, 8'h46, 8'h00, 5);
        send_pkt(8'hA5, 8'h10, 8'h02, 8'h11, 8'h00, 8'h00, 4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", valid, 1'b0);
        check("t6_rst_cmd", cmd, 8'h00);
        check("t6_rst_len", len, 5'd0);
        tick(1);
        rst_n = 1'b1;
        ready = 1'b1;
        send(8'h22); send(8'h21);
        check("t6_discarded", valid, 1'b0);
        send_pkt(8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 4);
        check("t6_after_rst", cmd, 8'h01);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
